// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and helpers for the ID/EX hazard controller
package hazard_ctrl_pkg;
  localparam int CTR_W = 8;
  typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_FLUSH} hazard_state_t;
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
  } hazard_ctrl_t;
  function automatic logic load_use(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2,
    input logic [4:0] rd,
    input logic       memread
  );
    return memread && rd != 5'd0 && ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
  endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  // count qualifying cycles, holding once every bit is set
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else if (inc && count_q != '1) count_q <= count_q + W'(1);
  end
  assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use interlock, taken-branch flush and data-memory wait control
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_br_taken,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import hazard_ctrl_pkg::*;
  localparam logic [CTR_W-1:0] MAX_W   = CTR_W'(MAX_WAIT);
  localparam logic [CTR_W-1:0] FLUSH_R = CTR_W'(FLUSH_CYCLES - 1);
  hazard_state_t    state_q, state_d;
  logic [CTR_W-1:0] flush_q, flush_d;
  logic [CTR_W-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic             lu;
  logic             br_acc;
  hazard_ctrl_t     ctl;
  // state, flush countdown, memory-wait watchdog; reset leaves nothing pending
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= HZ_RUN;
      flush_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  // priority decode: memory wait beats branch flush beats load-use bubble
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    wait_d    = '0;
    ctl       = '0;
    lu        = load_use(id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread);
    if (dmem_busy) begin
      ctl.pc_stall    = 1'b1;
      ctl.ifid_stall  = 1'b1;
      ctl.idex_stall  = 1'b1;
      ctl.exmem_stall = 1'b1;
      if (state_q != HZ_FLUSH) begin
        state_d = HZ_MEM_WAIT;
        wait_d  = (state_q != HZ_MEM_WAIT) ? CTR_W'(1) : (wait_q == MAX_W) ? wait_q : wait_q + CTR_W'(1);
      end
    end else if (ex_br_taken) begin
      ctl.ifid_flush = 1'b1;
      ctl.idex_flush = 1'b1;
      state_d        = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;
      flush_d        = (FLUSH_CYCLES > 1) ? FLUSH_R : '0;
    end else if (state_q == HZ_FLUSH) begin
      ctl.ifid_flush = 1'b1;
      flush_d        = flush_q - CTR_W'(1);
      state_d        = (flush_q == CTR_W'(1)) ? HZ_RUN : HZ_FLUSH;
    end else begin
      ctl.pc_stall   = lu;
      ctl.ifid_stall = lu;
      ctl.idex_flush = lu;
      state_d        = HZ_RUN;
    end
    timeout_d = timeout_q | (wait_d == MAX_W);
    if (!reset) ctl = '0;
  end
  assign br_acc      = reset && !dmem_busy && ex_br_taken;
  assign pc_stall    = ctl.pc_stall;
  assign ifid_stall  = ctl.ifid_stall;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_stall  = ctl.idex_stall;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_stall = ctl.exmem_stall;
  assign timeout     = timeout_q;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctl.pc_stall),
    .count (stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (br_acc),
    .count (flush_cnt)
  );
endmodule
